// File: rtl/cdec8_ctrl_pkg.sv
// Shared encodings for the CDEC8 control unit: bus codes, ALU ops, opcodes,
// state codes and the layout of the 17-bit control word.
package cdec8_ctrl_pkg;

  localparam logic [3:0] SRC_PC    = 4'h0;
  localparam logic [3:0] SRC_A     = 4'h1;
  localparam logic [3:0] SRC_B     = 4'h2;
  localparam logic [3:0] SRC_C     = 4'h3;
  localparam logic [3:0] SRC_R     = 4'h4;
  localparam logic [3:0] SRC_RDR   = 4'h5;
  localparam logic [3:0] SRC_FLG   = 4'h6;
  localparam logic [3:0] SRC_FF    = 4'h7;
  localparam logic [3:0] SRC_IPORT = 4'h8;
  localparam logic [3:0] SRC_NONE  = 4'hF;

  localparam logic [3:0] DST_PC    = 4'h0;
  localparam logic [3:0] DST_A     = 4'h1;
  localparam logic [3:0] DST_B     = 4'h2;
  localparam logic [3:0] DST_C     = 4'h3;
  localparam logic [3:0] DST_MAR   = 4'h4;
  localparam logic [3:0] DST_WDR   = 4'h5;
  localparam logic [3:0] DST_T     = 4'h6;
  localparam logic [3:0] DST_I     = 4'h7;
  localparam logic [3:0] DST_OPORT = 4'h8;
  localparam logic [3:0] DST_NONE  = 4'hF;

  localparam logic [1:0] MM_IDLE  = 2'b00;
  localparam logic [1:0] MM_READ  = 2'b10;
  localparam logic [1:0] MM_WRITE = 2'b01;

  localparam logic [4:0] ALU_THRX = 5'h00;
  localparam logic [4:0] ALU_ADD  = 5'h01;
  localparam logic [4:0] ALU_SUB  = 5'h03;
  localparam logic [4:0] ALU_AND  = 5'h05;
  localparam logic [4:0] ALU_OR   = 5'h06;
  localparam logic [4:0] ALU_XOR  = 5'h07;
  localparam logic [4:0] ALU_INC  = 5'h08;
  localparam logic [4:0] ALU_DEC  = 5'h09;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_HALT = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD = 4'h4, OP_SUB  = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR = 4'h8, OP_CMP  = 4'h9, OP_IN  = 4'hA, OP_OUT = 4'hB,
    OP_JMP = 4'hC, OP_JCC  = 4'hD, OP_INC = 4'hE, OP_DEC = 4'hF
  } op_e;

  typedef enum logic [7:0] {
    ST_IDLE = 8'h00, ST_F0 = 8'h01, ST_F1 = 8'h02, ST_F2 = 8'h03,
    ST_DEC  = 8'h04, ST_O0 = 8'h05, ST_O1 = 8'h06, ST_E0 = 8'h07,
    ST_E1   = 8'h08, ST_E2 = 8'h09, ST_HALT = 8'h0F
  } state_e;

  localparam int CTRL_W         = 17;
  localparam int CTRL_MMRW_LSB  = 15;
  localparam int CTRL_FWR       = 14;
  localparam int CTRL_RWR       = 13;
  localparam int CTRL_XDST_LSB  = 9;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_XSRC_LSB  = 0;

  typedef struct packed {
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [3:0] xdst;
    logic [4:0] aluop;
    logic [3:0] xsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{mmrw: MM_IDLE, fwr: 1'b0, rwr: 1'b0,
                                  xdst: DST_NONE, aluop: ALU_THRX, xsrc: SRC_NONE};

  // Register field 00/01/10 selects A/B/C, which share their bus codes; 11 has no register.
  function automatic logic [3:0] reg_code(input logic [1:0] sel);
    return (sel == 2'b11) ? 4'hF : {2'b00, sel} + 4'h1;
  endfunction

  function automatic logic [4:0] alu_of(input op_e op);
    case (op)
      OP_ADD:         return ALU_ADD;
      OP_SUB, OP_CMP: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_XOR:         return ALU_XOR;
      OP_INC:         return ALU_INC;
      OP_DEC:         return ALU_DEC;
      default:        return ALU_THRX;
    endcase
  endfunction

  function automatic logic writes_rd(input op_e op);
    return op inside {OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_IN, OP_INC, OP_DEC};
  endfunction

  function automatic logic jcc_taken(input logic [1:0] cc, input logic [2:0] szcy);
    case (cc)
      2'b00:   return szcy[1];
      2'b01:   return ~szcy[1];
      2'b10:   return szcy[0];
      default: return szcy[2];
    endcase
  endfunction

endpackage

// File: rtl/cdec8_ctrl_dec.sv
// Moore control-word decode: (state, instruction) -> datapath control word.
module cdec8_ctrl_dec
  import cdec8_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [7:0] i_instr,
  output ctrl_t      o_ctrl
);

  op_e        w_op;
  logic [3:0] w_rd;
  logic [3:0] w_src;
  logic       w_null;

  always_comb begin
    w_op   = op_e'(i_instr[7:4]);
    w_rd   = reg_code(i_instr[3:2]);
    w_src  = (i_instr[1:0] == 2'b11) ? SRC_RDR : reg_code(i_instr[1:0]);
    // rd=11 has no register: xdst already decodes to F, flags must stay untouched too
    w_null = writes_rd(w_op) && (i_instr[3:2] == 2'b11);
    o_ctrl = CTRL_IDLE;
    unique case (i_state)
      ST_F0, ST_O0: begin
        o_ctrl.xsrc  = SRC_PC;
        o_ctrl.xdst  = DST_MAR;
        o_ctrl.aluop = ALU_INC;
        o_ctrl.rwr   = 1'b1;
      end
      ST_F1, ST_O1: begin
        o_ctrl.mmrw = MM_READ;
        o_ctrl.xsrc = SRC_R;
        o_ctrl.xdst = DST_PC;
      end
      ST_F2: begin
        o_ctrl.xsrc = SRC_RDR;
        o_ctrl.xdst = DST_I;
      end
      ST_E0: begin
        case (w_op)
          OP_LD:  begin o_ctrl.xsrc = w_src;     o_ctrl.xdst = w_rd;    end
          OP_ST:  begin o_ctrl.xsrc = SRC_RDR;   o_ctrl.xdst = DST_MAR; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
            o_ctrl.xsrc = w_src;
            o_ctrl.xdst = DST_T;
          end
          OP_IN:  begin o_ctrl.xsrc = SRC_IPORT; o_ctrl.xdst = w_rd;      end
          OP_OUT: begin o_ctrl.xsrc = w_rd;      o_ctrl.xdst = DST_OPORT; end
          OP_JMP, OP_JCC: begin o_ctrl.xsrc = SRC_RDR; o_ctrl.xdst = DST_PC; end
          OP_INC, OP_DEC: begin
            o_ctrl.xsrc  = w_rd;
            o_ctrl.aluop = alu_of(w_op);
            o_ctrl.rwr   = 1'b1;
            o_ctrl.fwr   = ~w_null;
          end
          default: ;
        endcase
      end
      ST_E1: begin
        case (w_op)
          OP_ST: begin o_ctrl.xsrc = w_rd; o_ctrl.xdst = DST_WDR; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
            o_ctrl.xsrc  = w_rd;
            o_ctrl.aluop = alu_of(w_op);
            o_ctrl.rwr   = 1'b1;
            o_ctrl.fwr   = ~w_null;
          end
          OP_INC, OP_DEC: begin o_ctrl.xsrc = SRC_R; o_ctrl.xdst = w_rd; end
          default: ;
        endcase
      end
      ST_E2: begin
        case (w_op)
          OP_ST: o_ctrl.mmrw = MM_WRITE;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            o_ctrl.xsrc = SRC_R;
            o_ctrl.xdst = w_rd;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cdec8_ctrl.sv
// CDEC8 microsequencer: state register, instruction sequencing, Jcc latch.
//   state | meaning
//   IDLE  | waiting for run
//   F0-F2 | instruction fetch (PC->MAR/INC, read, RDR->I)
//   DEC   | decode, Jcc condition sampled
//   O0-O1 | immediate operand fetch
//   E0-E2 | execute steps
//   HALT  | stopped until reset
module cdec8_ctrl
  import cdec8_ctrl_pkg::*;
#(
  parameter logic [7:0] RESET_STATE = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  I,
  input  logic [2:0]  SZCy,
  output logic [16:0] ctrl,
  output logic [7:0]  state,
  output logic        halted
);

  state_e r_state;
  logic   r_take;
  state_e w_next;
  state_e w_boundary;
  logic   w_take_nxt;
  logic   w_imm;
  op_e    w_op;
  ctrl_t  w_ctrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= state_e'(RESET_STATE);
      r_take  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_take  <= w_take_nxt;
    end
  end

  always_comb begin
    w_op       = op_e'(I[7:4]);
    w_imm      = (I[1:0] == 2'b11);
    w_boundary = run ? ST_F0 : ST_IDLE;
    w_next     = r_state;
    w_take_nxt = r_take;
    case (r_state)
      ST_IDLE: if (run) w_next = ST_F0;
      ST_F0:   w_next = ST_F1;
      ST_F1:   w_next = ST_F2;
      ST_F2:   w_next = ST_DEC;
      ST_DEC: begin
        case (w_op)
          OP_NOP:  w_next = w_boundary;
          OP_HALT: w_next = ST_HALT;
          OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP:
            w_next = w_imm ? ST_O0 : ST_E0;
          OP_ST, OP_JMP: w_next = ST_O0;
          OP_JCC: begin
            w_next     = ST_O0;
            w_take_nxt = jcc_taken(I[1:0], SZCy);
          end
          default: w_next = ST_E0;
        endcase
      end
      ST_O0: w_next = ST_O1;
      ST_O1: begin
        // an untaken branch still consumes its operand byte, leaving PC+2
        if (w_op == OP_JCC && !r_take) w_next = w_boundary;
        else                           w_next = ST_E0;
      end
      ST_E0: begin
        if (w_op inside {OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_INC, OP_DEC})
          w_next = ST_E1;
        else
          w_next = w_boundary;
      end
      ST_E1: begin
        if (w_op inside {OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) w_next = ST_E2;
        else                                                            w_next = w_boundary;
      end
      ST_E2:   w_next = w_boundary;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  cdec8_ctrl_dec u_dec (
    .i_state (r_state),
    .i_instr (I),
    .o_ctrl  (w_ctrl)
  );

  assign ctrl   = w_ctrl;
  assign state  = r_state;
  assign halted = (r_state == ST_HALT);

endmodule

// File: doc/cdec8_ctrl.md
Name: cdec8_ctrl

Overview:
- Microsequencing control unit for the CDEC8 8-bit datapath.
- Consumes the instruction register I and the flag bits SZCy from the datapath.
- Drives the 17-bit datapath control word ctrl = {mmrw[1:0], fwr, rwr, xdst[3:0], aluop[4:0], xsrc[3:0]} as a Moore decode of its state register plus I/SZCy.
- Exports its state code to the debug monitor (resource address 0x0B).

Parameters:
- RESET_STATE, 8'h00, state code entered on reset (IDLE).

Ports:
- clock, input, 1, system clock, all state changes on rising edge.
- reset, input, 1, asynchronous active-high reset.
- run, input, 1, start/continue enable, sampled only at instruction boundaries.
- I, input, 8, instruction register from datapath.
- SZCy, input, 3, flags {S,Z,Cy} from datapath.
- ctrl, output, 17, datapath control word.
- state, output, 8, current state code for debug monitor.
- halted, output, 1, high while in HALT.

Behaviour:
- Bus codes. Sources xsrc: PC 0, A 1, B 2, C 3, R 4, RDR 5, FLG 6, FF 7, IPORT 8. Destinations xdst: PC 0, A 1, B 2, C 3, MAR 4, WDR 5, T 6, I 7, OPORT 8, none F.
- mmrw: 00 idle, 10 read (RDR <= mem[MAR] at that edge), 01 write (mem[MAR] <= WDR).
- IDLE ctrl word: mmrw 00, fwr 0, rwr 0, xdst F, aluop THRX, xsrc F. This is the default in every state unless a step below says otherwise.
- State codes: IDLE 00, F0 01, F1 02, F2 03, DEC 04, O0 05, O1 06, E0 07, E1 08, E2 09, HALT 0F.
- Reset, asynchronous: state = IDLE, ctrl = IDLE word, halted = 0. Reset mid-instruction abandons it with no further mmrw pulse.
- IDLE: go to F0 when run = 1.
- Fetch sequence, 4 cycles:
  - F0: PC->X, xdst MAR, aluop INC, rwr.
  - F1: mmrw 10, R->PC.
  - F2: RDR->I.
  - DEC: idle word; branch on I.
- Operand fetch (O0, O1), only where an instruction says so:
  - O0: PC->MAR, aluop INC, rwr.
  - O1: mmrw 10, R->PC.
- Instruction format: I[7:4] op, I[3:2] rd (00 A, 01 B, 10 C), I[1:0] src (00 A, 01 B, 10 C, 11 immediate byte).
- rd = 11 on any register-writing op: execute as NOP (xdst F, fwr 0).
- Instruction sequences:
  - 0 NOP: return directly.
  - 1 HALT: enter HALT; stays there until reset; halted = 1; run ignored.
  - 2 LD: register src: E0 src->rd. Immediate: O0, O1, E0 RDR->rd.
  - 3 ST rd,[imm]: O0, O1, E0 RDR->MAR, E1 rd->WDR, E2 mmrw 01.
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 CMP:
    - E0: src->T; immediate variant runs O0, O1 first and uses RDR->T.
    - E1: rd->X, aluop op, rwr, fwr.
    - E2: R->rd. Skipped for CMP (aluop SUB, flags only).
  - A IN: E0 IPORT->rd.
  - B OUT: E0 rd->OPORT.
  - C JMP [imm]: O0, O1, E0 RDR->PC.
  - D Jcc [imm]: condition from I[1:0] — 00 Z=1, 01 Z=0, 10 Cy=1, 11 S=1, tested on SZCy in DEC.
    - Condition true: as JMP.
    - Condition false: O0, O1 only (operand skipped, PC+2 overall).
  - E INC, F DEC: E0 rd->X, aluop INC/DEC, rwr, fwr; E1 R->rd.
- Boundary: after the last step of every instruction, go to F0 if run = 1, else IDLE. run changes mid-instruction have no effect.
- SZCy is sampled only in DEC for Jcc.
- ALU opcodes: THRX 00, ADD 01, SUB 03, AND 05, OR 06, XOR 07, INC 08, DEC 09.

Decomposition:
- Shared constants header holds:
  - xsrc/xdst codes;
  - mmrw codes;
  - ALU opcodes;
  - instruction opcodes;
  - state codes;
  - ctrl field positions.
- Optional sub-module cdec8_ctrl_dec: purely combinational (state, I, SZCy) -> ctrl. The state register and next-state logic stay in cdec8_ctrl.

Test Plan:
- Fetch: reset, run = 1, memory[0] = 0x00 (NOP) -> state 01, 02, 03, 04 then 01 again. F0 ctrl = {00,0,1,4,08,0}; PC advances to 1.
- LD A,#0x5A: bytes 0x23, 0x5A -> fetch, O0, O1, E0 with ctrl xsrc 5, xdst 1. A = 0x5A; PC = 2 after 7 cycles.
- ADD A,B with A = 0x80, B = 0x80 -> E1 drives aluop 01, rwr, fwr. Flags Z = 1, Cy = 1; A = 0x00 after E2. CMP variant leaves A unchanged.
- ST A,[0x40]: E2 is the only cycle with mmrw = 01. At that cycle MAR = 0x40 and WDR = A.
- Jcc: Z = 0 with JZ 0x10 -> PC = current + 2. Z = 1 -> PC = 0x10.
- HALT then reset asserted mid-HALT -> halted 1 until reset. Reset asynchronously forces state 00 and the IDLE ctrl word without waiting for a clock edge.
